// File: rtl/score_text_ctrl_if.sv
// Score update handshake between game logic (master) and the score text controller (slave).
interface score_text_ctrl_if #(
  parameter int SCORE_W = 14
);
  logic [SCORE_W-1:0] score_in;
  logic               score_valid;
  logic               score_ready;

  modport master (output score_in, output score_valid, input score_ready);
  modport slave  (input score_in, input score_valid, output score_ready);
endinterface

// File: rtl/score_text_ctrl.sv
// Score overlay controller: binary score -> double-dabble BCD -> atomic digit buffer -> ascii lookup.
// Optional SCORE_LZB_EN enables leading-zero blanking of the displayed digits.
module score_text_ctrl #(
  parameter int SCORE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                pclk,
  input  logic                rst,
  score_text_ctrl_if.slave    score,
  output logic                busy,
  output logic                overflow,
  input  logic [7:0]          char_xy,
  output logic [7:0]          ascii
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W:0] LIMIT = (SCORE_W + 1)'(10 ** DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  state_t                   state_reg, state_next;
  logic [SCORE_W-1:0]       shreg_reg, shreg_next;
  logic [BCD_W-1:0]         bcd_reg, bcd_next, bcd_adj;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     sat_reg, sat_next;
  logic                     overflow_reg, overflow_next;
  logic [3:0]               disp_reg [DIGITS];
  logic [3:0]               disp_next [DIGITS];
  logic [7:0]               ascii_reg, ascii_next;
  logic [7:0]               digit_char [DIGITS];
  logic [BCD_W+SCORE_W-1:0] shifted;

  // Add-3 correction on every nibble before the shift keeps each nibble a valid BCD digit.
  for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                               : bcd_reg[4*gi +: 4];
  end

  assign shifted = {bcd_adj, shreg_reg} << 1;

  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    sat_next      = sat_reg;
    overflow_next = overflow_reg;
    disp_next     = disp_reg;
    case (state_reg)
      IDLE: begin
        if (score.score_valid) begin
          if ({1'b0, score.score_in} >= LIMIT) begin
            sat_next   = 1'b1;
            state_next = WRITE;
          end else begin
            shreg_next = score.score_in;
            bcd_next   = '0;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_next   = shifted[BCD_W+SCORE_W-1 -: BCD_W];
        shreg_next = shifted[SCORE_W-1:0];
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(SCORE_W - 1)) state_next = WRITE;
      end
      WRITE: begin
        // All digits commit on this single edge so the overlay never sees a mixed value.
        for (int i = 0; i < DIGITS; i++) begin
          disp_next[i] = sat_reg ? 4'd9 : bcd_reg[4*(DIGITS-1-i) +: 4];
        end
        overflow_next = sat_reg;
        sat_next      = 1'b0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SCORE_LZB_EN
  logic [DIGITS-1:0] lead_zero;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_char
    if (gi == 0) begin : g_first
      assign lead_zero[gi] = (disp_reg[gi] == 4'd0);
    end else begin : g_rest
      assign lead_zero[gi] = lead_zero[gi-1] & (disp_reg[gi] == 4'd0);
    end
    // The units digit always shows, so a zero score still reads as "0".
    if (gi == DIGITS - 1) begin : g_last
      assign digit_char[gi] = 8'h30 + {4'd0, disp_reg[gi]};
    end else begin : g_blank
      assign digit_char[gi] = lead_zero[gi] ? 8'h20 : 8'h30 + {4'd0, disp_reg[gi]};
    end
  end
`else
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_char
    assign digit_char[gi] = 8'h30 + {4'd0, disp_reg[gi]};
  end
`endif

  always_comb begin
    ascii_next = 8'h20;
    for (int i = 0; i < DIGITS; i++) begin
      if (char_xy == 8'(i)) ascii_next = digit_char[i];
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      sat_reg      <= 1'b0;
      overflow_reg <= 1'b0;
      ascii_reg    <= 8'h20;
      for (int i = 0; i < DIGITS; i++) disp_reg[i] <= 4'd0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      sat_reg      <= sat_next;
      overflow_reg <= overflow_next;
      ascii_reg    <= ascii_next;
      disp_reg     <= disp_next;
    end
  end

  assign score.score_ready = (state_reg == IDLE);
  assign busy              = (state_reg != IDLE);
  assign overflow          = overflow_reg;
  assign ascii             = ascii_reg;

endmodule

// File: tb/tb_score_text_ctrl.sv
// Directed plus random checks of score_text_ctrl against a decimal-arithmetic display model.
module tb_score_text_ctrl;
  localparam int SCORE_W = 14;
  localparam int DIGITS  = 4;
  localparam int LIMIT   = 10 ** DIGITS;

  logic       pclk = 1'b0;
  logic       rst;
  logic       busy, overflow;
  logic [7:0] char_xy, ascii;

  score_text_ctrl_if #(.SCORE_W(SCORE_W)) sif ();

  score_text_ctrl #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) dut (
    .pclk     (pclk),
    .rst      (rst),
    .score    (sif),
    .busy     (busy),
    .overflow (overflow),
    .char_xy  (char_xy),
    .ascii    (ascii)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  int model_val = 0;
  bit model_sat = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int idx);
    int p;
    if (idx >= DIGITS) return 8'h20;
    if (model_sat) return 8'h39;
    p = 10 ** (DIGITS - 1 - idx);
`ifdef SCORE_LZB_EN
    if (idx != DIGITS - 1 && model_val < p) return 8'h20;
`endif
    return 8'h30 + 8'((model_val / p) % 10);
  endfunction

  task automatic model_update(input int v);
    if (v >= LIMIT) begin
      model_sat = 1'b1;
    end else begin
      model_sat = 1'b0;
      model_val = v;
    end
  endtask

  task automatic check_display(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      char_xy = 8'(i);
      @(negedge pclk);
      check($sformatf("%s_ch%0d", tag, i), {24'd0, ascii}, {24'd0, exp_char(i)});
    end
  endtask

  task automatic send(input string tag, input int v);
    int n;
    n = 0;
    @(negedge pclk);
    sif.score_in    = SCORE_W'(v);
    sif.score_valid = 1'b1;
    while (!sif.score_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check({tag, "_ready"}, {31'd0, sif.score_ready}, 32'd1);
    @(negedge pclk);
    sif.score_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge pclk);
    end
    model_update(v);
    check({tag, "_busycyc"}, n, (v >= LIMIT) ? 1 : 15);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, model_sat});
    $display("update %s score=%0d busy_cycles=%0d overflow=%0b", tag, v, n, overflow);
  endtask

  initial begin
    int n;
    int v;
    rst = 1'b1;
    sif.score_in    = '0;
    sif.score_valid = 1'b0;
    char_xy         = 8'd0;
    repeat (2) @(negedge pclk);
    check("rst_ready", {31'd0, sif.score_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ascii", {24'd0, ascii}, 32'h20);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    check_display("reset", 6);
    check("idle_ready", {31'd0, sif.score_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    send("s1234", 1234);
    check_display("s1234", 4);

    send("s10000", 10000);
    check_display("s10000", 4);
    send("s42", 42);
    check_display("s42", 4);

    // 5678 accepted, then 9999 held valid across the whole conversion.
    @(negedge pclk);
    sif.score_in    = 14'd5678;
    sif.score_valid = 1'b1;
    @(negedge pclk);
    sif.score_in = 14'd9999;
    n = 0;
    while (busy && n < 50) begin
      check("b2b_not_ready", {31'd0, sif.score_ready}, 32'd0);
      n++;
      @(negedge pclk);
    end
    check("b2b_busycyc", n, 15);
    check("b2b_first_idle_ready", {31'd0, sif.score_ready}, 32'd1);
    model_update(5678);
    @(negedge pclk);
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    sif.score_valid = 1'b0;
    check_display("b2b_old", 4);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge pclk);
    end
    check("b2b_done", {31'd0, busy}, 32'd0);
    model_update(9999);
    check("b2b_ovf", {31'd0, overflow}, 32'd0);
    check_display("b2b_new", 4);
    $display("update b2b 5678 then 9999 held");

    send("s7", 7);
    check_display("s7", 4);
    send("s0", 0);
    check_display("s0", 4);
    send("s1005", 1005);
    check_display("s1005", 4);

    // Reset in the middle of a conversion, with overflow previously set.
    send("pre_abort", 16383);
    @(negedge pclk);
    sif.score_in    = 14'd4321;
    sif.score_valid = 1'b1;
    @(negedge pclk);
    sif.score_valid = 1'b0;
    repeat (5) @(negedge pclk);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, sif.score_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    model_val = 0;
    model_sat = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
    check_display("abort", 4);
    $display("update abort 4321 by reset");
    send("after_abort", 321);
    check_display("after_abort", 4);

    send("b9999", 9999);
    check_display("b9999", 4);
    send("b10000", 10000);
    check_display("b10000", 4);

    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(0, (1 << SCORE_W) - 1));
      if (k % 3 == 0) v = int'($urandom_range(0, 99));
      send($sformatf("rnd%0d", k), v);
      check_display($sformatf("rnd%0d", k), 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
